io_bus_dispatcher: RTL

Sits on the FPGA side of the HPS external-bus bridge (the `io_*` conduit) and shares that single bus among up to `NUM_SLOTS` fabric peripherals. It latches each bridge transaction, decodes the slot from the upper address bits and runs a req/ack handshake with the selected peripheral. It then returns exactly one `io_acknowledge` pulse per transaction. It also enforces a per-transaction timeout, masks and aggregates peripheral interrupts onto `io_irq`, and hosts a small local status register window.

---
 rtl/io_bus_pkg.sv | 26 ++
 rtl/io_bus_dispatcher_if.sv | 25 ++
 rtl/io_bus_local_regs.sv | 75 +++++++
 rtl/io_bus_dispatcher.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared definitions for the HPS bridge dispatcher.
//   state_t          dispatcher FSM states
//   LOCAL_SLOT       slot index that selects the local status window
//   OFF_*            word offsets (io_address[3:1]) inside the local window
//   DEFAULT_ERR_DATA read data returned on decode error or timeout
package io_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOCAL,
        ST_ERR,
        ST_ACK,
        ST_DONE
    } state_t;

    localparam logic [3:0]  LOCAL_SLOT       = 4'hF;

    localparam logic [2:0]  OFF_IRQ_PEND     = 3'd0;
    localparam logic [2:0]  OFF_IRQ_EN       = 3'd1;
    localparam logic [2:0]  OFF_TO_CNT       = 3'd2;
    localparam logic [2:0]  OFF_TO_ADDR      = 3'd3;

    localparam logic [15:0] DEFAULT_ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/io_bus_dispatcher_if.sv
// io_bus_dispatcher_if: the io_* conduit of the HPS external-bus bridge.
//   master modport: bridge side (drives request, address, data)
//   slave modport : dispatcher side (returns read data, ack, irq)
interface io_bus_dispatcher_if;

    logic        io_bus_enable;
    logic        io_rw;
    logic [15:0] io_address;
    logic [1:0]  io_byte_enable;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;

    modport master (
        output io_bus_enable, io_rw, io_address, io_byte_enable, io_write_data,
        input  io_read_data, io_acknowledge, io_irq
    );

    modport slave (
        input  io_bus_enable, io_rw, io_address, io_byte_enable, io_write_data,
        output io_read_data, io_acknowledge, io_irq
    );

endinterface

// File: rtl/io_bus_local_regs.sv
// io_bus_local_regs: local status window of the dispatcher.
//   clk, reset   clock, async active-high reset
//   wr_en        one-cycle write strobe for the addressed register
//   offset       word offset inside the window
//   be, wdata    byte lanes and write data
//   to_inc       one-cycle timeout event
//   to_addr_in   address of the transaction that timed out
//   slv_irq      peripheral level interrupts
//   rdata        combinational read data for offset
//   irq          registered OR of enabled pending interrupts
module io_bus_local_regs
    import io_bus_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [2:0]           offset,
    input  logic [1:0]           be,
    input  logic [15:0]          wdata,
    input  logic                 to_inc,
    input  logic [15:0]          to_addr_in,
    input  logic [NUM_SLOTS-1:0] slv_irq,
    output logic [15:0]          rdata,
    output logic                 irq
);

    // Only the low NUM_SLOTS bits of IRQ_EN exist; the rest stay constant 0.
    localparam logic [15:0] SLOT_MASK = 16'((32'd1 << NUM_SLOTS) - 32'd1);

    logic [15:0]          irq_en;
    logic [15:0]          to_cnt;
    logic [15:0]          to_addr;
    logic [15:0]          lane_mask;
    logic [NUM_SLOTS-1:0] pend;

    assign lane_mask = {{8{be[1]}}, {8{be[0]}}};
    assign pend      = slv_irq & irq_en[NUM_SLOTS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en  <= '0;
            to_cnt  <= '0;
            to_addr <= '0;
            irq     <= 1'b0;
        end else begin
            irq <= |pend;

            if (wr_en && offset == OFF_IRQ_EN)
                irq_en <= (irq_en & ~lane_mask) | (wdata & lane_mask & SLOT_MASK);

            // A clear wins over a simultaneous timeout increment.
            if (wr_en && offset == OFF_TO_CNT)
                to_cnt <= '0;
            else if (to_inc && to_cnt != 16'hFFFF)
                to_cnt <= to_cnt + 16'd1;

            if (to_inc)
                to_addr <= to_addr_in;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_IRQ_PEND: rdata = 16'(pend);
            OFF_IRQ_EN:   rdata = irq_en;
            OFF_TO_CNT:   rdata = to_cnt;
            OFF_TO_ADDR:  rdata = to_addr;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: rtl/io_bus_dispatcher.sv
// io_bus_dispatcher: shares the HPS bridge conduit among NUM_SLOTS fabric
// peripherals with a req/ack handshake, per-transaction timeout, interrupt
// aggregation and a local status window at slot 4'hF.
//   clk, reset              clock, async active-high reset
//   bus (slave)             io_* bridge conduit
//   slv_req                 one-hot request to the addressed slot
//   slv_rw/addr/be/wdata    latched transaction fields, shared by all slots
//   slv_ack                 per-slot single-cycle completion
//   slv_rdata               slot k read word at [16k+15:16k]
//   slv_irq                 per-slot level interrupts
//
// state | meaning
// IDLE  | waiting for io_bus_enable; latches the transaction
// REQ   | slv_req asserted, waiting for slot ack or timeout
// LOCAL | one-cycle local register access
// ERR   | unpopulated slot or timeout; returns ERR_DATA
// ACK   | loads the one-cycle io_acknowledge pulse
// DONE  | ignores io_bus_enable while the bridge deasserts it
module io_bus_dispatcher
    import io_bus_pkg::*;
#(
    parameter int          NUM_SLOTS      = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic                   clk,
    input  logic                   reset,
    io_bus_dispatcher_if.slave     bus,
    output logic [NUM_SLOTS-1:0]   slv_req,
    output logic                   slv_rw,
    output logic [11:0]            slv_addr,
    output logic [1:0]             slv_be,
    output logic [15:0]            slv_wdata,
    input  logic [NUM_SLOTS-1:0]   slv_ack,
    input  logic [16*NUM_SLOTS-1:0] slv_rdata,
    input  logic [NUM_SLOTS-1:0]   slv_irq
);

    localparam logic [3:0]  SLOT_LIMIT = 4'(NUM_SLOTS);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        capture;
    logic        local_wr;
    logic        to_inc;

    logic        rw_q;
    logic [15:0] addr_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [15:0] tmo_cnt;
    logic        ack_q;
    logic [15:0] read_data_q;
    logic        irq;

    logic [3:0]  in_slot;
    logic [3:0]  slot_q;
    logic        sel_ack;
    logic [15:0] sel_rdata;
    logic [15:0] local_rdata;

    assign in_slot   = bus.io_address[15:12];
    assign slot_q    = addr_q[15:12];
    assign slv_rw    = rw_q;
    assign slv_addr  = addr_q[11:0];
    assign slv_be    = be_q;
    assign slv_wdata = wdata_q;

    assign bus.io_acknowledge = ack_q;
    assign bus.io_read_data   = read_data_q;
    assign bus.io_irq         = irq;

    // Request is decoded from state so reset removes it without waiting for a clock.
    always_comb begin
        slv_req   = '0;
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q == 4'(k)) begin
                slv_req[k] = (state == ST_REQ);
                sel_ack    = slv_ack[k];
                sel_rdata  = slv_rdata[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        local_wr   = 1'b0;
        to_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.io_bus_enable) begin
                    capture = 1'b1;
                    if (in_slot < SLOT_LIMIT)
                        state_next = ST_REQ;
                    else if (in_slot == LOCAL_SLOT)
                        state_next = ST_LOCAL;
                    else
                        state_next = ST_ERR;
                end
            end
            ST_REQ: begin
                // An ack on the timeout edge still completes normally.
                if (sel_ack) begin
                    state_next = ST_ACK;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ST_ERR;
                    to_inc     = 1'b1;
                end
            end
            ST_LOCAL: begin
                local_wr   = !rw_q;
                state_next = ST_ACK;
            end
            ST_ERR:  state_next = ST_ACK;
            ST_ACK:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            tmo_cnt     <= '0;
            ack_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            ack_q       <= 1'b0;
            read_data_q <= '0;
            if (capture) begin
                rw_q    <= bus.io_rw;
                addr_q  <= bus.io_address;
                be_q    <= bus.io_byte_enable;
                wdata_q <= bus.io_write_data;
                tmo_cnt <= '0;
            end
            case (state)
                ST_REQ: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (sel_ack)
                        rdata_q <= sel_rdata;
                end
                ST_LOCAL: rdata_q <= local_rdata;
                ST_ERR:   rdata_q <= ERR_DATA;
                ST_ACK: begin
                    ack_q       <= 1'b1;
                    read_data_q <= rw_q ? rdata_q : 16'h0000;
                end
                default: ;
            endcase
        end
    end

    io_bus_local_regs #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_local_regs (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (local_wr),
        .offset     (addr_q[3:1]),
        .be         (be_q),
        .wdata      (wdata_q),
        .to_inc     (to_inc),
        .to_addr_in (addr_q),
        .slv_irq    (slv_irq),
        .rdata      (local_rdata),
        .irq        (irq)
    );

endmodule
